// File: rtl/sparse_sched_pkg.sv
// Shared types and constants for the sparse x dense multiply dispatch scheduler.
package sparse_sched_pkg;

  // Sequencer states: one FETCH/LATCH/DISPATCH/WAIT pass per sparse entry.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_DISPATCH,
    ST_WAIT,
    ST_FINISH
  } state_e;

  // Bit positions of the two shift fields inside a sparse memory word.
  localparam int HIGH_MSB = 31;
  localparam int HIGH_LSB = 16;
  localparam int LOW_MSB  = 15;
  localparam int LOW_LSB  = 0;

  localparam int SHIFT_W  = 16;
  localparam int WEIGHT_W = 7;

  localparam int DEF_POLY_BITS  = 17669;
  localparam int DEF_MAX_WEIGHT = 50;

  // Unsigned 16-bit range check; limit must stay below 2^16.
  function automatic logic shift_out_of_range(input logic [SHIFT_W-1:0] shift,
                                              input int                 limit);
    return shift >= SHIFT_W'(limit);
  endfunction

endpackage

// File: rtl/sparse_entry_decoder.sv
// Combinational decode of one sparse entry: field split, range checks and
// dummy classification.
module sparse_entry_decoder
  import sparse_sched_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int POLY_BITS  = DEF_POLY_BITS
) (
  input  logic [WORD_WIDTH-1:0] word_i,
  input  logic [ADDR_WIDTH-1:0] idx_i,
  input  logic [ADDR_WIDTH:0]   weight_i,
  output logic [SHIFT_W-1:0]    high_o,
  output logic [SHIFT_W-1:0]    low_o,
  output logic                  dummy_o,
  output logic                  range_err_o
);

  logic past_weight;
  logic high_bad;
  logic low_bad;

  // Split the word and classify it; only real entries can raise a range error.
  always_comb begin
    high_o      = word_i[HIGH_MSB:HIGH_LSB];
    low_o       = word_i[LOW_MSB:LOW_LSB];
    past_weight = {1'b0, idx_i} >= weight_i;
    high_bad    = shift_out_of_range(high_o, POLY_BITS);
    low_bad     = shift_out_of_range(low_o, POLY_BITS);
    dummy_o     = past_weight | high_bad | low_bad;
    range_err_o = ~past_weight & (high_bad | low_bad);
  end

endmodule

// File: rtl/sparse_dispatch_scheduler.sv
// Top-level sequencer: walks all MAX_WEIGHT sparse entries in constant time and
// hands each (high, low) shift pair to the multiply engine via start/done.
module sparse_dispatch_scheduler
  import sparse_sched_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WEIGHT = DEF_MAX_WEIGHT,
  parameter int POLY_BITS  = DEF_POLY_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WEIGHT_W-1:0]   weight,
  output logic [ADDR_WIDTH-1:0] sparse_mem_addr_o,
  input  logic [WORD_WIDTH-1:0] sparse_mem_data_i,
  output logic                  eng_start_o,
  output logic [SHIFT_W-1:0]    eng_high_shift_o,
  output logic [SHIFT_W-1:0]    eng_low_shift_o,
  output logic                  eng_dummy_o,
  input  logic                  eng_done_i,
  output logic [ADDR_WIDTH-1:0] entry_idx_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  // weight_q must be able to hold MAX_WEIGHT itself, which may equal 2^ADDR_WIDTH.
  localparam int                    WQ_W         = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX     = ADDR_WIDTH'(MAX_WEIGHT - 1);
  localparam logic [WQ_W-1:0]       MAX_WEIGHT_Q = WQ_W'(MAX_WEIGHT);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [ADDR_WIDTH-1:0] idx_d;
  logic [WQ_W-1:0]       weight_q;
  logic [WQ_W-1:0]       weight_d;
  logic                  weight_over;
  logic                  eng_start_q;
  logic [SHIFT_W-1:0]    high_q;
  logic [SHIFT_W-1:0]    low_q;
  logic                  dummy_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;

  logic [SHIFT_W-1:0]    dec_high;
  logic [SHIFT_W-1:0]    dec_low;
  logic                  dec_dummy;
  logic                  dec_range_err;

  sparse_entry_decoder #(
    .WORD_WIDTH (WORD_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .POLY_BITS  (POLY_BITS)
  ) u_decoder (
    .word_i      (sparse_mem_data_i),
    .idx_i       (idx_q),
    .weight_i    (weight_q),
    .high_o      (dec_high),
    .low_o       (dec_low),
    .dummy_o     (dec_dummy),
    .range_err_o (dec_range_err)
  );

  // Clamp the requested weight to MAX_WEIGHT and compute the next entry index.
  always_comb begin
    weight_over = 32'(weight) > 32'(MAX_WEIGHT);
    weight_d    = weight_over ? MAX_WEIGHT_Q : WQ_W'(weight);
    idx_d       = idx_q + ADDR_WIDTH'(1);
  end

  // Sequencer FSM with all outputs registered; every entry costs the same time.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      weight_q    <= '0;
      eng_start_q <= 1'b0;
      high_q      <= '0;
      low_q       <= '0;
      dummy_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            idx_q    <= '0;
            weight_q <= weight_d;
            err_q    <= weight_over;
            busy_q   <= 1'b1;
            state_q  <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // Address is driven from idx_q; data arrives next cycle.
          state_q <= ST_LATCH;
        end
        ST_LATCH: begin
          high_q      <= dec_high;
          low_q       <= dec_low;
          dummy_q     <= dec_dummy;
          err_q       <= err_q | dec_range_err;
          eng_start_q <= 1'b1;
          state_q     <= ST_DISPATCH;
        end
        ST_DISPATCH: begin
          // A done seen here belongs to nobody and is dropped.
          eng_start_q <= 1'b0;
          state_q     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (eng_done_i) begin
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= ST_FINISH;
            end else begin
              idx_q   <= idx_d;
              state_q <= ST_FETCH;
            end
          end
        end
        ST_FINISH: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sparse_mem_addr_o = idx_q;
  assign entry_idx_o       = idx_q;
  assign eng_start_o       = eng_start_q;
  assign eng_high_shift_o  = high_q;
  assign eng_low_shift_o   = low_q;
  assign eng_dummy_o       = dummy_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign err_o             = err_q;

endmodule
